// File: rtl/ncpu32k_ifu_pcgen.sv
// Fetch PC generator and in-order instruction queue feeding decode.
// Redirects drop queued entries and swallow responses owed to killed fetches.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module ncpu32k_ifu_pcgen #(
    parameter logic [`NCPU_AW-3:0] CONFIG_PC_RESET_VECTOR = '0,
    parameter int                  CONFIG_IFQ_DEPTH       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifu_flush,
    input  logic [`NCPU_AW-3:0]  ifu_flush_tgt,
    output logic [`NCPU_AW-3:0]  bpu_insn_pc,
    input  logic                 bpu_pred_taken,
    input  logic [`NCPU_AW-3:0]  bpu_pred_tgt,
    output logic                 ibus_cmd_valid,
    input  logic                 ibus_cmd_ready,
    output logic [`NCPU_AW-3:0]  ibus_cmd_addr,
    input  logic                 ibus_rsp_valid,
    input  logic [31:0]          ibus_rsp_insn,
    output logic                 idu_valid,
    input  logic                 idu_ready,
    output logic [31:0]          idu_insn,
    output logic [`NCPU_AW-3:0]  idu_pc,
    output logic                 idu_pred_taken,
    output logic [`NCPU_AW-3:0]  idu_pred_tgt
);
    localparam int W  = `NCPU_AW - 2;
    localparam int D  = CONFIG_IFQ_DEPTH;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d;

    logic [W-1:0]  ent_pc_q [D];
    logic [W-1:0]  ent_pc_d [D];
    logic [W-1:0]  ent_tgt_q [D];
    logic [W-1:0]  ent_tgt_d [D];
    logic [31:0]   ent_insn_q [D];
    logic [31:0]   ent_insn_d [D];
    logic [D-1:0]  ent_taken_q, ent_taken_d;
    logic [D-1:0]  ent_filled_q, ent_filled_d;

    logic [CW:0]   occ;
    logic [CW-1:0] n_filled;
    logic          cmd_hs;
    logic          idu_hs;

    // Killed fetches still occupy bus slots until their responses drain.
    assign occ            = {1'b0, cnt_q} + {1'b0, kill_cnt_q};
    assign ibus_cmd_valid = ~rst & ~ifu_flush & (occ < (CW+1)'(D));
    assign ibus_cmd_addr  = pc_q;
    assign bpu_insn_pc    = pc_q;
    assign cmd_hs         = ibus_cmd_valid & ibus_cmd_ready;

    assign idu_valid      = ~rst & ~ifu_flush & ent_filled_q[rd_ptr_q]
                          & (cnt_q != '0);
    assign idu_hs         = idu_valid & idu_ready;
    assign idu_insn       = ent_insn_q[rd_ptr_q];
    assign idu_pc         = ent_pc_q[rd_ptr_q];
    assign idu_pred_taken = ent_taken_q[rd_ptr_q];
    assign idu_pred_tgt   = ent_tgt_q[rd_ptr_q];

    always_comb begin
        n_filled = '0;
        for (int i = 0; i < D; i++) begin
            n_filled = n_filled + CW'(ent_filled_q[i]);
        end
    end

    always_comb begin
        pc_d         = pc_q;
        wr_ptr_d     = wr_ptr_q;
        fill_ptr_d   = fill_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        kill_cnt_d   = kill_cnt_q;
        ent_pc_d     = ent_pc_q;
        ent_tgt_d    = ent_tgt_q;
        ent_insn_d   = ent_insn_q;
        ent_taken_d  = ent_taken_q;
        ent_filled_d = ent_filled_q;

        if (ifu_flush) begin
            // Every allocated-but-unfilled entry still owes one response.
            pc_d         = ifu_flush_tgt;
            wr_ptr_d     = '0;
            fill_ptr_d   = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            ent_filled_d = '0;
            kill_cnt_d   = kill_cnt_q + (cnt_q - n_filled)
                         - CW'(ibus_rsp_valid);
        end else begin
            if (ibus_rsp_valid) begin
                if (kill_cnt_q != '0) begin
                    kill_cnt_d = kill_cnt_q - CW'(1);
                end else begin
                    ent_insn_d[fill_ptr_q]   = ibus_rsp_insn;
                    ent_filled_d[fill_ptr_q] = 1'b1;
                    fill_ptr_d               = fill_ptr_q + PW'(1);
                end
            end
            if (idu_hs) begin
                ent_filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d               = rd_ptr_q + PW'(1);
            end
            if (cmd_hs) begin
                ent_pc_d[wr_ptr_q]     = pc_q;
                ent_taken_d[wr_ptr_q]  = bpu_pred_taken;
                ent_tgt_d[wr_ptr_q]    = bpu_pred_tgt;
                ent_filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                pc_d = bpu_pred_taken ? bpu_pred_tgt : pc_q + W'(1);
            end
            cnt_d = cnt_q + CW'(cmd_hs) - CW'(idu_hs);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= CONFIG_PC_RESET_VECTOR;
            wr_ptr_q     <= '0;
            fill_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            kill_cnt_q   <= '0;
            ent_filled_q <= '0;
        end else begin
            pc_q         <= pc_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_ptr_q   <= fill_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            kill_cnt_q   <= kill_cnt_d;
            ent_filled_q <= ent_filled_d;
        end
    end

    // Payload is qualified by the filled bits, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_tgt_q   <= ent_tgt_d;
        ent_insn_q  <= ent_insn_d;
        ent_taken_q <= ent_taken_d;
    end

endmodule

// File: tb/tb_ncpu32k_ifu_pcgen.sv
// Bench for ncpu32k_ifu_pcgen: directed cycle table, then random traffic
// against a queue-level model of fetch, fill, retire and redirect.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module tb_ncpu32k_ifu_pcgen;
    localparam int W = `NCPU_AW - 2;
    localparam int D = 2;
    localparam logic [W-1:0] RV = W'('h100);

    logic          clk;
    logic          rst;
    logic          ifu_flush;
    logic [W-1:0]  ifu_flush_tgt;
    logic [W-1:0]  bpu_insn_pc;
    logic          bpu_pred_taken;
    logic [W-1:0]  bpu_pred_tgt;
    logic          ibus_cmd_valid;
    logic          ibus_cmd_ready;
    logic [W-1:0]  ibus_cmd_addr;
    logic          ibus_rsp_valid;
    logic [31:0]   ibus_rsp_insn;
    logic          idu_valid;
    logic          idu_ready;
    logic [31:0]   idu_insn;
    logic [W-1:0]  idu_pc;
    logic          idu_pred_taken;
    logic [W-1:0]  idu_pred_tgt;

    ncpu32k_ifu_pcgen #(
        .CONFIG_PC_RESET_VECTOR (RV),
        .CONFIG_IFQ_DEPTH       (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_flush      (ifu_flush),
        .ifu_flush_tgt  (ifu_flush_tgt),
        .bpu_insn_pc    (bpu_insn_pc),
        .bpu_pred_taken (bpu_pred_taken),
        .bpu_pred_tgt   (bpu_pred_tgt),
        .ibus_cmd_valid (ibus_cmd_valid),
        .ibus_cmd_ready (ibus_cmd_ready),
        .ibus_cmd_addr  (ibus_cmd_addr),
        .ibus_rsp_valid (ibus_rsp_valid),
        .ibus_rsp_insn  (ibus_rsp_insn),
        .idu_valid      (idu_valid),
        .idu_ready      (idu_ready),
        .idu_insn       (idu_insn),
        .idu_pc         (idu_pc),
        .idu_pred_taken (idu_pred_taken),
        .idu_pred_tgt   (idu_pred_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pc;
        bit           tk;
        logic [W-1:0] tgt;
        bit           filled;
        logic [31:0]  insn;
    } ent_t;

    typedef struct {
        logic [W-1:0] addr;
        int           cyc;
    } bus_t;

    typedef struct {
        bit           r;
        bit           fl;
        logic [W-1:0] ft;
        bit           tk;
        logic [W-1:0] pt;
        bit           crdy;
        bit           rsp;
        bit           irdy;
        bit           ecv;
        logic [W-1:0] eca;
        bit           eiv;
        logic [W-1:0] eipc;
        bit           eit;
        logic [W-1:0] eitgt;
    } vec_t;

    ent_t         q[$];
    bus_t         busq[$];
    vec_t         vecs[$];
    logic [W-1:0] pc_m;
    int           kill_m;
    int           cyc;
    int           delivered;
    int           checks;
    int           errors;

    function automatic logic [31:0] mem(input logic [W-1:0] a);
        return 32'({a, 2'b01}) ^ 32'hC3A5_1E69;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic add(input int r, input int fl, input int ft,
                       input int tk, input int pt, input int crdy,
                       input int rsp, input int irdy, input int ecv,
                       input int eca, input int eiv, input int eipc,
                       input int eit, input int eitgt);
        vec_t v;
        v.r = r[0];       v.fl = fl[0];      v.ft = W'(ft);
        v.tk = tk[0];     v.pt = W'(pt);     v.crdy = crdy[0];
        v.rsp = rsp[0];   v.irdy = irdy[0];  v.ecv = ecv[0];
        v.eca = W'(eca);  v.eiv = eiv[0];    v.eipc = W'(eipc);
        v.eit = eit[0];   v.eitgt = W'(eitgt);
        vecs.push_back(v);
    endtask

    task automatic drive(input bit r, input bit fl, input logic [W-1:0] ft,
                         input bit tk, input logic [W-1:0] pt,
                         input bit crdy, input bit want_rsp,
                         input bit irdy);
        bit ok;
        @(negedge clk);
        rst            = r;
        ifu_flush      = fl;
        ifu_flush_tgt  = ft;
        bpu_pred_taken = tk;
        bpu_pred_tgt   = pt;
        ibus_cmd_ready = crdy;
        idu_ready      = irdy;
        ok = 1'b0;
        ibus_rsp_insn = '0;
        if (!r && busq.size() > 0) begin
            if (busq[0].cyc < cyc) begin
                ok = 1'b1;
                ibus_rsp_insn = mem(busq[0].addr);
            end
        end
        ibus_rsp_valid = want_rsp && ok;
        #1;
    endtask

    task automatic model_check();
        bit ecv;
        bit eiv;
        ecv = !rst && !ifu_flush && (q.size() + kill_m < D);
        eiv = !rst && !ifu_flush && q.size() > 0;
        if (eiv) eiv = q[0].filled;
        chk("cmd_valid", 64'(ibus_cmd_valid), 64'(ecv));
        if (!rst) chk("bpu_insn_pc", 64'(bpu_insn_pc), 64'(pc_m));
        if (ecv) chk("cmd_addr", 64'(ibus_cmd_addr), 64'(pc_m));
        chk("idu_valid", 64'(idu_valid), 64'(eiv));
        if (eiv) begin
            chk("idu_pc", 64'(idu_pc), 64'(q[0].pc));
            chk("idu_insn", 64'(idu_insn), 64'(q[0].insn));
            chk("idu_pred_taken", 64'(idu_pred_taken), 64'(q[0].tk));
            chk("idu_pred_tgt", 64'(idu_pred_tgt), 64'(q[0].tgt));
        end
    endtask

    task automatic model_step();
        bit chs;
        bit ihs;
        bit found;
        int unf;
        if (rst) begin
            pc_m = RV;
            q.delete();
            busq.delete();
            kill_m = 0;
            return;
        end
        chs = !ifu_flush && (q.size() + kill_m < D) && ibus_cmd_ready;
        ihs = !ifu_flush && q.size() > 0 && idu_ready;
        if (ihs) ihs = q[0].filled;
        if (ibus_rsp_valid) void'(busq.pop_front());
        if (ifu_flush) begin
            unf = 0;
            foreach (q[i]) if (!q[i].filled) unf++;
            kill_m = kill_m + unf - (ibus_rsp_valid ? 1 : 0);
            q.delete();
            pc_m = ifu_flush_tgt;
            return;
        end
        if (ibus_rsp_valid) begin
            if (kill_m > 0) begin
                kill_m--;
            end else begin
                found = 1'b0;
                foreach (q[i]) begin
                    if (!found && !q[i].filled) begin
                        q[i].filled = 1'b1;
                        q[i].insn = ibus_rsp_insn;
                        found = 1'b1;
                    end
                end
            end
        end
        if (ihs) begin
            void'(q.pop_front());
            delivered++;
        end
        if (chs) begin
            q.push_back('{pc_m, bpu_pred_taken, bpu_pred_tgt, 1'b0, 32'h0});
            busq.push_back('{pc_m, cyc});
            pc_m = bpu_pred_taken ? bpu_pred_tgt : pc_m + W'(1);
        end
    endtask

    task automatic tick();
        model_check();
        model_step();
        cyc++;
    endtask

    initial begin
        logic [W-1:0] ft;
        logic [W-1:0] pt;
        checks = 0;
        errors = 0;
        cyc = 0;
        delivered = 0;
        kill_m = 0;
        pc_m = RV;
        rst = 1'b1;
        ifu_flush = 1'b0;
        ifu_flush_tgt = '0;
        bpu_pred_taken = 1'b0;
        bpu_pred_tgt = '0;
        ibus_cmd_ready = 1'b0;
        ibus_rsp_valid = 1'b0;
        ibus_rsp_insn = '0;
        idu_ready = 1'b0;

        // r fl ftgt tk ptgt crdy rsp irdy | cv addr | iv pc tk tgt
        add(1,0,0,    0,0,    1,0,1, 0,0,     0,0,0,0);
        add(1,0,0,    0,0,    1,0,1, 0,0,     0,0,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h100, 0,0,0,0);
        add(0,0,0,    1,'h200,1,1,1, 1,'h101, 0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 0,0,     1,'h100,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h200, 1,'h101,1,'h200);
        add(0,0,0,    0,0,    1,1,1, 1,'h201, 0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 0,0,     1,'h200,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h202, 1,'h201,0,0);
        add(0,0,0,    0,0,    1,1,0, 1,'h203, 0,0,0,0);
        add(0,0,0,    0,0,    1,1,0, 0,0,     1,'h202,0,0);
        add(0,0,0,    0,0,    1,0,0, 0,0,     1,'h202,0,0);
        add(0,0,0,    0,0,    1,0,1, 0,0,     1,'h202,0,0);
        add(0,0,0,    0,0,    1,0,0, 1,'h204, 1,'h203,0,0);
        add(0,0,0,    0,0,    1,0,1, 0,0,     1,'h203,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h205, 0,0,0,0);
        add(0,1,'h300,0,0,    1,0,1, 0,0,     0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 0,0,     0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 1,'h300, 0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 1,'h301, 0,0,0,0);
        add(0,0,0,    0,0,    1,0,1, 0,0,     1,'h300,0,0);
        add(0,0,0,    0,0,    1,1,1, 1,'h302, 0,0,0,0);
        add(0,1,'h380,0,0,    1,1,1, 0,0,     0,0,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h380, 0,0,0,0);
        add(0,0,0,    0,0,    1,1,1, 1,'h381, 0,0,0,0);
        add(0,0,0,    0,0,    1,0,0, 0,0,     1,'h380,0,0);
        add(1,0,0,    0,0,    1,0,1, 0,0,     0,0,0,0);
        add(1,0,0,    0,0,    1,0,1, 0,0,     0,0,0,0);
        add(0,0,0,    0,0,    1,0,1, 1,'h100, 0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].fl, vecs[i].ft, vecs[i].tk,
                  vecs[i].pt, vecs[i].crdy, vecs[i].rsp, vecs[i].irdy);
            chk($sformatf("row%0d cmd_valid", i),
                64'(ibus_cmd_valid), 64'(vecs[i].ecv));
            if (vecs[i].ecv)
                chk($sformatf("row%0d cmd_addr", i),
                    64'(ibus_cmd_addr), 64'(vecs[i].eca));
            chk($sformatf("row%0d idu_valid", i),
                64'(idu_valid), 64'(vecs[i].eiv));
            if (vecs[i].eiv) begin
                chk($sformatf("row%0d idu_pc", i),
                    64'(idu_pc), 64'(vecs[i].eipc));
                chk($sformatf("row%0d idu_insn", i),
                    64'(idu_insn), 64'(mem(vecs[i].eipc)));
                chk($sformatf("row%0d idu_pred_taken", i),
                    64'(idu_pred_taken), 64'(vecs[i].eit));
                chk($sformatf("row%0d idu_pred_tgt", i),
                    64'(idu_pred_tgt), 64'(vecs[i].eitgt));
            end
            tick();
        end

        // Random traffic, including redirects and predictions to the top
        // of the address space so the PC increment wraps.
        for (int n = 0; n < 4000; n++) begin
            ft = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
            pt = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 15) == 0, ft,
                  $urandom_range(0, 3) == 0, pt,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 7);
            tick();
        end
        chk("progress", 64'(delivered > 500), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
